simon_stream_if: RTL
====================

// Module: simon_stream_if
// PURPOSE
//  Word-serial front end for the SIMON round controller. It assembles N-bit input words into a
//  full key (M words) and a 2N-bit block, then drives the controller's newKey/newData/enc_dec/plain/key.
//  It waits for doneData, captures cipher, acknowledges with readData, and streams the result out
//  as two N-bit words. Sits between the system bus and the SIMON round controller.
// PARAMETERS
//  N   16  word size in bits (block is 2N)
//  M   4   key words
//  KW  2   width of key-word counter, = $clog2(M)
// PORTS
//  clk       in   1      system clock, all flops on posedge
//  nR        in   1      asynchronous reset, active low
//  in_valid  in   1      input word valid
//  in_ready  out  1      input word accepted when in_valid && in_ready
//  in_word   in   N      input word
//  in_is_key in   1      1: word is a key word; 0: word is a data word
//  in_enc    in   1      encrypt(1)/decrypt(0); sampled with the 2nd (low) data word
//  out_valid out  1      output word valid
//  out_ready in   1      output word taken when out_valid && out_ready
//  out_word  out  N      output word
//  newData   out  1      to controller: block ready
//  newKey    out  1      to controller: new key ready
//  enc_dec   out  1      to controller: mode
//  readData  out  1      to controller: result consumed
//  plain     out  2N     to controller: block
//  key       out  M*N    to controller: key, packed [M-1:0][N-1:0]
//  ldKey     in   1      from controller: key expansion in progress
//  doneData  in   1      from controller: cipher valid
//  cipher    in   2N     from controller: result block
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, keyPend 0, state IDLE; in_ready=1 only in IDLE.
//  Word order
//   - Key: key[0] first up to key[M-1].
//   - Block in: plain[2N-1:N] first, then plain[N-1:0].
//   - Block out: cipher[2N-1:N] first.
//  FSM IDLE -> ISSUE -> WAIT -> SEND_HI -> SEND_LO -> ACK -> IDLE.
//  IDLE: in_ready=1. Key and data words are counted independently (kcnt, dcnt).
//   - The M-th key word sets keyPend=1 and wraps kcnt to 0.
//   - A new full key overwrites the pending one.
//   - The 2nd data word latches enc_dec<=in_enc, clears dcnt, and moves to ISSUE next cycle.
//   - A data completion and a key completion in the same cycle cannot occur (one word per cycle).
//  ISSUE: newData=1; newKey=keyPend.
//   - newKey drops and keyPend clears on the first cycle ldKey=1 is sampled.
//   - newData drops on the first cycle doneData=1 is sampled.
//   - Leaves for WAIT immediately (1 cycle).
//  WAIT: holds newData/newKey per the drop rules above.
//   - On doneData=1: capture cipher into obuf, drop newData, go to SEND_HI.
//  SEND_HI/SEND_LO: out_valid=1, out_word = obuf upper/lower.
//   - Advance only on out_ready. out_word stays stable while stalled.
//  ACK: readData=1, held until doneData sampled 0, then readData=0 and go to IDLE.
//   - Minimum 1 cycle.
//  in_ready=0 outside IDLE, so no input is lost. Partial dcnt/kcnt persist across a block.
//  Latency from last input word to newData=1 is 1 cycle. Controller-to-out_valid is 1 cycle after doneData.
//  Async reset mid-operation aborts everything.
//   - All outputs go to 0 immediately and partial words are discarded.
//   - The controller must be reset by the same nR.
// STRUCTURE
//  simon_pkg: typedef enum logic [2:0] {IDLE,ISSUE,WAIT,SEND_HI,SEND_LO,ACK} sif_state_t; default N/M constants.
//  Sub-module simon_word_sreg #(N,DEPTH): shift-in word register with count and full pulse.
//   - Instantiate twice: DEPTH=M for the key, DEPTH=2 for the block.
//  FSM, obuf, and handshake flags stay in this module.
// TESTING
//  1. Reset with all inputs 0 -> all outputs 0, in_ready=1, state IDLE.
//  2. Encrypt with the SIMON32/64 vector.
//     Stimulus: key words 0100,0908,1110,1918, then data 6565,6877 with in_enc=1.
//     Response: key=1918_1110_0908_0100, plain=65656877, newKey=newData=1, enc_dec=1; out words c69b then e9bb.
//  3. Decrypt with the same key, no key reload.
//     Stimulus: data c69b,e9bb with in_enc=0.
//     Response: newKey=0, enc_dec=0; out words 6565 then 6877.
//  4. Hold out_ready=0 for 10 cycles in SEND_HI -> out_word=c69b stable, in_ready=0, readData=0.
//  5. Reset while in WAIT -> outputs 0 same cycle; a fresh key/data load then works with no stale words.
//  6. Interleave key words and data words (k0,d0,k1,k2,k3,d1) -> key and block assembled correctly; newKey=1 with newData.

Source files
------------

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and default sizes for the SIMON stream front end
// Contents:
//   SIMON_N, SIMON_M, SIMON_KW : default word size, key words, key-word counter width
//   sif_state_t                : front-end FSM state encoding
package simon_pkg;

    localparam int SIMON_N  = 16;
    localparam int SIMON_M  = 4;
    localparam int SIMON_KW = $clog2(SIMON_M);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        SEND_HI = 3'd3,
        SEND_LO = 3'd4,
        ACK     = 3'd5
    } sif_state_t;

endpackage

// File: rtl/simon_stream_if_if.sv
// rtl/simon_stream_if_if.sv - bus bundle between system side, front end and SIMON round controller
// Signals:
//   in_*      : word-serial input stream (valid/ready)
//   out_*     : word-serial output stream (valid/ready)
//   newData, newKey, enc_dec, readData, plain, key : front end -> controller
//   ldKey, doneData, cipher                        : controller -> front end
// Modports:
//   slave  : the front end (simon_stream_if)
//   master : the environment (system bus source/sink plus round controller)
interface simon_stream_if_if #(
    parameter int N = 16,
    parameter int M = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          in_word;
    logic                  in_is_key;
    logic                  in_enc;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          out_word;
    logic                  newData;
    logic                  newKey;
    logic                  enc_dec;
    logic                  readData;
    logic [2*N-1:0]        plain;
    logic [M-1:0][N-1:0]   key;
    logic                  ldKey;
    logic                  doneData;
    logic [2*N-1:0]        cipher;

    modport slave (
        input  in_valid, in_word, in_is_key, in_enc, out_ready,
        input  ldKey, doneData, cipher,
        output in_ready, out_valid, out_word,
        output newData, newKey, enc_dec, readData, plain, key
    );

    modport master (
        output in_valid, in_word, in_is_key, in_enc, out_ready,
        output ldKey, doneData, cipher,
        input  in_ready, out_valid, out_word,
        input  newData, newKey, enc_dec, readData, plain, key
    );

endinterface

// File: rtl/simon_word_sreg.sv
// rtl/simon_word_sreg.sv - word-at-a-time assembly register with slot counter and full pulse
// Ports:
//   clk, nR   : clock, asynchronous active-low reset
//   i_valid   : accept i_word this cycle
//   i_word    : N-bit word
//   o_full    : combinational pulse, high on the cycle the DEPTH-th word is accepted
//   o_next    : assembled vector including the word being accepted this cycle
// FIRST_HIGH=1 places the first word in the top slot (block order); 0 places it in slot 0 (key order).
module simon_word_sreg #(
    parameter int N          = 16,
    parameter int DEPTH      = 2,
    parameter int CW         = 1,
    parameter bit FIRST_HIGH = 1'b1
) (
    input  logic                      clk,
    input  logic                      nR,
    input  logic                      i_valid,
    input  logic [N-1:0]              i_word,
    output logic                      o_full,
    output logic [DEPTH-1:0][N-1:0]   o_next
);

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [DEPTH-1:0][N-1:0] r_data;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_slot;

    assign w_slot = FIRST_HIGH ? (LAST - r_cnt) : r_cnt;
    assign o_full = i_valid && (r_cnt == LAST);

    // Presenting the merged value lets the owner capture a complete vector
    // on the same edge the final word arrives.
    always_comb begin
        o_next         = r_data;
        o_next[w_slot] = i_word;
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_valid) begin
            r_data <= o_next;
            r_cnt  <= o_full ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/simon_stream_if.sv
// rtl/simon_stream_if.sv - word-serial front end for the SIMON round controller
// Ports:
//   clk  : system clock
//   nR   : asynchronous active-low reset, shared with the controller
//   bus  : simon_stream_if_if.slave - input/output word streams and controller handshake
// Key words assemble key[0]..key[M-1]; block words assemble plain hi then lo; the result
// streams out cipher hi then lo, followed by a readData handshake.
module simon_stream_if
    import simon_pkg::*;
#(
    parameter int N  = SIMON_N,
    parameter int M  = SIMON_M,
    parameter int KW = SIMON_KW
) (
    input  logic                 clk,
    input  logic                 nR,
    simon_stream_if_if.slave     bus
);

    sif_state_t           r_state;
    sif_state_t           w_state_nxt;

    logic                 r_key_pend;
    logic                 r_new_key;
    logic                 r_new_data;
    logic                 r_enc_dec;
    logic                 r_read_data;
    logic [2*N-1:0]       r_plain;
    logic [M-1:0][N-1:0]  r_key;
    logic [2*N-1:0]       r_obuf;

    logic                 w_accept;
    logic                 w_key_v;
    logic                 w_dat_v;
    logic                 w_key_full;
    logic                 w_dat_full;
    logic [M-1:0][N-1:0]  w_key_next;
    logic [1:0][N-1:0]    w_blk_next;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_key_v  = w_accept && bus.in_is_key;
    assign w_dat_v  = w_accept && !bus.in_is_key;

    simon_word_sreg #(
        .N          (N),
        .DEPTH      (M),
        .CW         (KW),
        .FIRST_HIGH (1'b0)
    ) u_key_sreg (
        .clk     (clk),
        .nR      (nR),
        .i_valid (w_key_v),
        .i_word  (bus.in_word),
        .o_full  (w_key_full),
        .o_next  (w_key_next)
    );

    simon_word_sreg #(
        .N          (N),
        .DEPTH      (2),
        .CW         (1),
        .FIRST_HIGH (1'b1)
    ) u_blk_sreg (
        .clk     (clk),
        .nR      (nR),
        .i_valid (w_dat_v),
        .i_word  (bus.in_word),
        .o_full  (w_dat_full),
        .o_next  (w_blk_next)
    );

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_dat_full)     w_state_nxt = ISSUE;
            ISSUE:                       w_state_nxt = WAIT;
            WAIT:    if (bus.doneData)   w_state_nxt = SEND_HI;
            SEND_HI: if (bus.out_ready)  w_state_nxt = SEND_LO;
            SEND_LO: if (bus.out_ready)  w_state_nxt = ACK;
            ACK:     if (!bus.doneData)  w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    // Assembled key/block are copied into holding registers only when complete,
    // so a partially loaded next key never disturbs what the controller sees.
    // Clears are written before sets so a completion always wins.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_key_pend  <= 1'b0;
            r_new_key   <= 1'b0;
            r_new_data  <= 1'b0;
            r_enc_dec   <= 1'b0;
            r_read_data <= 1'b0;
            r_plain     <= '0;
            r_key       <= '0;
            r_obuf      <= '0;
        end else begin
            if (r_new_key && bus.ldKey) begin
                r_new_key  <= 1'b0;
                r_key_pend <= 1'b0;
            end
            if (r_new_data && bus.doneData) begin
                r_new_data <= 1'b0;
            end

            if (w_key_full) begin
                r_key      <= w_key_next;
                r_key_pend <= 1'b1;
            end
            if (w_dat_full) begin
                r_plain    <= w_blk_next;
                r_enc_dec  <= bus.in_enc;
                r_new_data <= 1'b1;
                r_new_key  <= r_key_pend;
            end

            if (r_state == WAIT && bus.doneData) begin
                r_obuf <= bus.cipher;
            end

            if (r_state == SEND_LO && bus.out_ready) begin
                r_read_data <= 1'b1;
            end else if (r_state == ACK && !bus.doneData) begin
                r_read_data <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == SEND_HI) || (r_state == SEND_LO);
    assign bus.out_word  = (r_state == SEND_HI) ? r_obuf[2*N-1:N] :
                           (r_state == SEND_LO) ? r_obuf[N-1:0]   : '0;
    assign bus.newData   = r_new_data;
    assign bus.newKey    = r_new_key;
    assign bus.enc_dec   = r_enc_dec;
    assign bus.readData  = r_read_data;
    assign bus.plain     = r_plain;
    assign bus.key       = r_key;

endmodule
